alu_issue_queue: RTL

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/iq_wakeup_match.sv | 26 ++
 rtl/alu_issue_queue.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types for the ALU issue queue: dispatch, bypass and issue buses plus
// the per-entry payload the queue keeps for each waiting instruction.
package cpu_pkg;

  localparam int XLEN                 = 32;
  localparam int PREG_W               = 6;
  localparam int ROB_W                = 5;
  localparam int IQ_DEPTH_DEFAULT     = 4;
  localparam int WAKEUP_PORTS_DEFAULT = 3;

  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic [31:0]      inst;
    preg_t            phy_dest;
    preg_t            phy_src1;
    preg_t            phy_src2;
    logic             src1_ready;
    logic             src2_ready;
    logic [XLEN-1:0]  src1_value;
    logic [XLEN-1:0]  src2_value;
    logic [ROB_W-1:0] rob_entry_num;
  } iq_dispatch_bus_t;

  typedef struct packed {
    logic [3:0]      rf_we;
    preg_t           phy_dest;
    logic [XLEN-1:0] value;
  } bypass_bus_t;

  typedef struct packed {
    logic [31:0]      inst;
    preg_t            phy_dest;
    logic [XLEN-1:0]  src1_value;
    logic [XLEN-1:0]  src2_value;
    logic [ROB_W-1:0] rob_entry_num;
  } issue_to_execute_bus_t;

  // Everything an entry keeps besides its operand readiness and values
  typedef struct packed {
    logic [31:0]      inst;
    preg_t            phy_dest;
    preg_t            phy_src1;
    preg_t            phy_src2;
    logic [ROB_W-1:0] rob_entry_num;
  } iq_payload_t;

  function automatic iq_payload_t to_payload(input iq_dispatch_bus_t d);
    iq_payload_t p;
    p.inst          = d.inst;
    p.phy_dest      = d.phy_dest;
    p.phy_src1      = d.phy_src1;
    p.phy_src2      = d.phy_src2;
    p.rob_entry_num = d.rob_entry_num;
    return p;
  endfunction

endpackage

// File: rtl/iq_wakeup_match.sv
// Compares one source tag against every bypass bus; the lowest-indexed writing
// port with a matching destination wins.
module iq_wakeup_match
  import cpu_pkg::*;
#(
  parameter int WAKEUP_PORTS = WAKEUP_PORTS_DEFAULT
) (
  input  preg_t           i_tag,
  input  bypass_bus_t     i_wakeup_bus [WAKEUP_PORTS],
  output logic            o_hit,
  output logic [XLEN-1:0] o_value
);

  // Scanning from the top down lets the lowest matching port overwrite the rest
  always_comb begin
    o_hit   = 1'b0;
    o_value = '0;
    for (int p = WAKEUP_PORTS - 1; p >= 0; p--) begin
      if ((i_wakeup_bus[p].rf_we != 4'b0000) && (i_wakeup_bus[p].phy_dest == i_tag)) begin
        o_hit   = 1'b1;
        o_value = i_wakeup_bus[p].value;
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Age-ordered ALU issue queue: oldest-ready select, shift-down compaction on issue,
// operand wakeup from the bypass buses for stored and incoming entries.
module alu_issue_queue
  import cpu_pkg::*;
#(
  parameter int IQ_DEPTH     = IQ_DEPTH_DEFAULT,
  parameter int WAKEUP_PORTS = WAKEUP_PORTS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  dispatch_valid,
  output logic                  iq_allowin,
  input  iq_dispatch_bus_t      dispatch_inst,
  input  bypass_bus_t           wakeup_bus [WAKEUP_PORTS],
  output logic                  issue_to_alu_valid,
  input  logic                  alu_allowin,
  output issue_to_execute_bus_t issue_inst
);

  localparam int CNT_W = $clog2(IQ_DEPTH + 1);
  localparam int IDX_W = $clog2(IQ_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);

  logic [IQ_DEPTH-1:0] r_valid;
  logic [CNT_W-1:0]    r_count;
  iq_payload_t         r_payload    [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] r_src1_ready;
  logic [IQ_DEPTH-1:0] r_src2_ready;
  logic [XLEN-1:0]     r_src1_value [IQ_DEPTH];
  logic [XLEN-1:0]     r_src2_value [IQ_DEPTH];

  logic [IQ_DEPTH-1:0] w_hit1;
  logic [IQ_DEPTH-1:0] w_hit2;
  logic [XLEN-1:0]     w_wake1      [IQ_DEPTH];
  logic [XLEN-1:0]     w_wake2      [IQ_DEPTH];
  logic                w_d_hit1;
  logic                w_d_hit2;
  logic [XLEN-1:0]     w_d_wake1;
  logic [XLEN-1:0]     w_d_wake2;

  logic [IQ_DEPTH-1:0] w_wk_rdy1;
  logic [IQ_DEPTH-1:0] w_wk_rdy2;
  logic [XLEN-1:0]     w_wk_val1    [IQ_DEPTH];
  logic [XLEN-1:0]     w_wk_val2    [IQ_DEPTH];
  logic                w_d_rdy1;
  logic                w_d_rdy2;
  logic [XLEN-1:0]     w_d_val1;
  logic [XLEN-1:0]     w_d_val2;

  logic                w_sel_found;
  logic [IDX_W-1:0]    w_sel_idx;
  logic                w_disp_fire;
  logic                w_issue_fire;
  logic [CNT_W-1:0]    w_wpos;
  logic [CNT_W-1:0]    w_count_next;
  logic [IQ_DEPTH-1:0] w_valid_next;
  iq_payload_t         w_nx_payload [IQ_DEPTH];
  logic [IQ_DEPTH-1:0] w_nx_rdy1;
  logic [IQ_DEPTH-1:0] w_nx_rdy2;
  logic [XLEN-1:0]     w_nx_val1    [IQ_DEPTH];
  logic [XLEN-1:0]     w_nx_val2    [IQ_DEPTH];

  for (genvar g = 0; g < IQ_DEPTH; g++) begin : g_entry_match
    iq_wakeup_match #(.WAKEUP_PORTS(WAKEUP_PORTS)) u_src1 (
      .i_tag(r_payload[g].phy_src1), .i_wakeup_bus(wakeup_bus),
      .o_hit(w_hit1[g]), .o_value(w_wake1[g])
    );
    iq_wakeup_match #(.WAKEUP_PORTS(WAKEUP_PORTS)) u_src2 (
      .i_tag(r_payload[g].phy_src2), .i_wakeup_bus(wakeup_bus),
      .o_hit(w_hit2[g]), .o_value(w_wake2[g])
    );
  end

  iq_wakeup_match #(.WAKEUP_PORTS(WAKEUP_PORTS)) u_disp_src1 (
    .i_tag(dispatch_inst.phy_src1), .i_wakeup_bus(wakeup_bus),
    .o_hit(w_d_hit1), .o_value(w_d_wake1)
  );
  iq_wakeup_match #(.WAKEUP_PORTS(WAKEUP_PORTS)) u_disp_src2 (
    .i_tag(dispatch_inst.phy_src2), .i_wakeup_bus(wakeup_bus),
    .o_hit(w_d_hit2), .o_value(w_d_wake2)
  );

  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      w_wk_rdy1[i] = r_src1_ready[i] | w_hit1[i];
      w_wk_rdy2[i] = r_src2_ready[i] | w_hit2[i];
      w_wk_val1[i] = (!r_src1_ready[i] && w_hit1[i]) ? w_wake1[i] : r_src1_value[i];
      w_wk_val2[i] = (!r_src2_ready[i] && w_hit2[i]) ? w_wake2[i] : r_src2_value[i];
    end
  end

  // Physical register 0 is hardwired zero, so it never waits on a producer
  always_comb begin
    w_d_rdy1 = 1'b1;
    w_d_val1 = '0;
    w_d_rdy2 = 1'b1;
    w_d_val2 = '0;
    if (dispatch_inst.phy_src1 != '0) begin
      w_d_rdy1 = dispatch_inst.src1_ready | w_d_hit1;
      w_d_val1 = dispatch_inst.src1_ready ? dispatch_inst.src1_value : w_d_wake1;
    end
    if (dispatch_inst.phy_src2 != '0) begin
      w_d_rdy2 = dispatch_inst.src2_ready | w_d_hit2;
      w_d_val2 = dispatch_inst.src2_ready ? dispatch_inst.src2_value : w_d_wake2;
    end
  end

  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
      if (r_valid[i] && r_src1_ready[i] && r_src2_ready[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_to_alu_valid = w_sel_found;
  assign iq_allowin         = (r_count < DEPTH_C) && !flush;
  assign w_disp_fire        = dispatch_valid && iq_allowin;
  assign w_issue_fire       = w_sel_found && alu_allowin;
  assign w_wpos             = r_count - CNT_W'(w_issue_fire);
  assign w_count_next       = r_count + CNT_W'(w_disp_fire) - CNT_W'(w_issue_fire);

  always_comb begin
    issue_inst.inst          = r_payload[w_sel_idx].inst;
    issue_inst.phy_dest      = r_payload[w_sel_idx].phy_dest;
    issue_inst.src1_value    = r_src1_value[w_sel_idx];
    issue_inst.src2_value    = r_src2_value[w_sel_idx];
    issue_inst.rob_entry_num = r_payload[w_sel_idx].rob_entry_num;
  end

  // Woken state first, then compaction past the issued slot, then the new entry
  always_comb begin
    for (int j = 0; j < IQ_DEPTH; j++) begin
      w_nx_payload[j] = r_payload[j];
      w_nx_rdy1[j]    = w_wk_rdy1[j];
      w_nx_rdy2[j]    = w_wk_rdy2[j];
      w_nx_val1[j]    = w_wk_val1[j];
      w_nx_val2[j]    = w_wk_val2[j];
    end
    for (int j = 0; j < IQ_DEPTH - 1; j++) begin
      if (w_issue_fire && (IDX_W'(j) >= w_sel_idx)) begin
        w_nx_payload[j] = r_payload[j+1];
        w_nx_rdy1[j]    = w_wk_rdy1[j+1];
        w_nx_rdy2[j]    = w_wk_rdy2[j+1];
        w_nx_val1[j]    = w_wk_val1[j+1];
        w_nx_val2[j]    = w_wk_val2[j+1];
      end
    end
    for (int j = 0; j < IQ_DEPTH; j++) begin
      if (w_disp_fire && (CNT_W'(j) == w_wpos)) begin
        w_nx_payload[j] = to_payload(dispatch_inst);
        w_nx_rdy1[j]    = w_d_rdy1;
        w_nx_rdy2[j]    = w_d_rdy2;
        w_nx_val1[j]    = w_d_val1;
        w_nx_val2[j]    = w_d_val2;
      end
      w_valid_next[j] = CNT_W'(j) < w_count_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_valid_next;
      r_count <= w_count_next;
    end
  end

  // Storage is qualified by r_valid, so it needs no reset
  always_ff @(posedge clk) begin
    for (int j = 0; j < IQ_DEPTH; j++) begin
      r_payload[j]    <= w_nx_payload[j];
      r_src1_ready[j] <= w_nx_rdy1[j];
      r_src2_ready[j] <= w_nx_rdy2[j];
      r_src1_value[j] <= w_nx_val1[j];
      r_src2_value[j] <= w_nx_val2[j];
    end
  end

endmodule
